// File: rtl/bufram_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bufram_drain_pkg
// Description : Shared definitions for the buffer-RAM drain block: the
//               controller state encoding and the stream data width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bufram_drain_pkg;

    // Width of one buffer RAM word and of the output stream data.
    localparam int DATA_WIDTH = 32;

    // Controller states: IDLE waits for start, RUN drains a burst.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : bufram_drain_pkg
`default_nettype wire

// File: rtl/bufram_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bufram_drain_fifo
// Description : 2-entry FIFO with valid/ready on both sides. The head entry
//               drives out_data directly, so the output holds steady while
//               the consumer stalls. count exposes the occupancy so the
//               producer can do credit-based flow control.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid/in_ready   - write side handshake, in_data payload
//               out_valid/out_ready - read side handshake, out_data payload
//               count               - current occupancy (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module bufram_drain_fifo
    import bufram_drain_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rptr];
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Storage is cleared so the visible head reads as zero after reset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= in_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : bufram_drain_fifo
`default_nettype wire

// File: rtl/bufram_drain.sv
`default_nettype none
// ============================================================================
// Module      : bufram_drain
// Description : Drains a burst of len words from addresses 0..len-1 of an
//               external buffer RAM (port B, 1-cycle read latency) onto a
//               valid/ready stream, marking the final word with out_last.
// Ports       : clk, rst_n                - clock, async active-low reset
//               start, len                - burst request (sampled when idle)
//               busy, done                - burst status, done = end pulse
//               ram_addr, ram_we, ram_di  - RAM port B request (read only)
//               ram_do                    - RAM port B read data
//               out_data/out_valid/out_ready/out_last - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module bufram_drain
    import bufram_drain_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_we,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH:0] c_one     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_max_len = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_icnt;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic                  r_done;

    logic [ADDR_WIDTH:0]   w_len_clamped;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_last_hs;
    logic [2:0]            w_occ_next;
    logic [1:0]            w_fifo_count;
    logic                  w_fifo_in_ready;

    // Port B is used read-only.
    assign ram_we = 4'b0000;
    assign ram_di = '0;

    assign busy = (r_state == RUN);
    assign done = r_done;

    always_comb begin
        w_len_clamped = len;
        if (len == '0) begin
            w_len_clamped = c_one;
        end else if (len > c_max_len) begin
            w_len_clamped = c_max_len;
        end
    end

    assign w_pop     = out_valid && out_ready;
    assign w_last_hs = w_pop && out_last;

    // Credit check: occupancy the FIFO will have once this cycle's pop and
    // the in-flight read have landed. A new read only lands a cycle later,
    // so issuing while this is below 2 can never overflow the FIFO, and it
    // still permits one read per cycle while the consumer keeps up.
    assign w_occ_next = {1'b0, w_fifo_count} + {2'b00, r_rd_valid} - {2'b00, w_pop};

    assign w_issue = (r_state == RUN) && (r_icnt < r_len) && (w_occ_next < 3'd2);

    // The issue counter stops at len (<= 2^ADDR_WIDTH), so the address taken
    // from its low bits never wraps. Between reads the last address is held.
    assign ram_addr = w_issue ? r_icnt[ADDR_WIDTH-1:0] : r_addr_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= c_one;
            r_icnt      <= '0;
            r_addr_hold <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= (r_state == RUN) && w_last_hs;
            r_rd_valid <= w_issue;
            r_rd_last  <= w_issue && (r_icnt == (r_len - c_one));
            if (w_issue) begin
                r_icnt      <= r_icnt + c_one;
                r_addr_hold <= r_icnt[ADDR_WIDTH-1:0];
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_len   <= w_len_clamped;
                        r_icnt  <= '0;
                    end
                end
                RUN: begin
                    if (w_last_hs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read data enters the FIFO in the cycle it is valid on ram_do. The
    // credit check guarantees in_ready here; gating on it is only a guard.
    bufram_drain_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_rd_valid && w_fifo_in_ready),
        .in_ready  (w_fifo_in_ready),
        .in_data   ({r_rd_last, ram_do}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_last, out_data}),
        .count     (w_fifo_count)
    );

endmodule : bufram_drain
`default_nettype wire

// File: tb/tb_bufram_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_bufram_drain
// Description : Self-checking bench for bufram_drain (ADDR_WIDTH=3) with a
//               1-cycle-latency RAM model and a word-list reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bufram_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        busy;
    logic        done;
    logic [2:0]  ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_di;
    logic [31:0] ram_do;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [8];
    int          cyc = 0;
    int          cur_n = 8;
    int          stall_err = 0;
    int          addr_err = 0;
    logic        stall_prev = 1'b0;
    logic [33:0] stall_snap = '0;
    logic [31:0] got_d [$];
    logic        got_l [$];
    int          got_t [$];

    bufram_drain #(
        .ADDR_WIDTH (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_di    (ram_di),
        .ram_do    (ram_do),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port B: read data valid one clock after the address.
    always @(posedge clk) ram_do <= mem[ram_addr];

    // Stream monitor: collects handshaken words, watches stall stability
    // and how far reads run ahead of accepted words.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev && ({out_valid, out_last, out_data} !== stall_snap))
                stall_err <= stall_err + 1;
            if (busy && ((int'(ram_addr) >= cur_n) || (int'(ram_addr) > got_d.size() + 2)))
                addr_err <= addr_err + 1;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                got_t.push_back(cyc);
            end
            stall_prev <= out_valid && !out_ready;
            stall_snap <= {out_valid, out_last, out_data};
        end else begin
            stall_prev <= 1'b0;
        end
    end

    function automatic int clamp_len(input int l);
        if (l < 1) return 1;
        if (l > 8) return 8;
        return l;
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
    endtask

    // Call at a negedge; start is sampled at the following posedge.
    task automatic launch(input int n_req, input int n_exp);
        got_d.delete();
        got_l.delete();
        got_t.delete();
        cur_n = n_exp;
        len   = 4'(n_req);
        start = 1'b1;
    endtask

    // k counts posedges from the one that samples start (k=0). Observations
    // are made at the negedge after posedge k. Returns at the done negedge.
    task automatic run_burst(input int mode, input int ign_k, output int first_k,
                             output int done_k, output int busy_cnt, output int t0);
        first_k  = -1;
        done_k   = -1;
        busy_cnt = 0;
        t0       = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) t0 = cyc;
            start = (k == ign_k);
            if (k == ign_k) len = 4'($urandom_range(1, 8));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((k % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (busy) busy_cnt++;
            if (out_valid && first_k < 0) first_k = k;
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = 4'd0; out_ready = 1'b1;
        load_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (ram_addr !== 3'd0)  begin errors++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL reset_we: got %b want 0000", ram_we); end
        checks++; if (ram_di !== 32'h0)   begin errors++; $display("FAIL reset_di: got %h want 0", ram_di); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_burst_ready(input int n_req, input string nm);
        int first_k, done_k, busy_cnt, t0, n;
        n = clamp_len(n_req);
        load_ramp();
        @(negedge clk);
        launch(n_req, n);
        run_burst(0, -1, first_k, done_k, busy_cnt, t0);
        checks++; if (first_k != 2) begin errors++; $display("FAIL %s_first_valid: got k=%0d want 2", nm, first_k); end
        checks++; if (got_d.size() != n) begin errors++; $display("FAIL %s_count: got %0d want %0d", nm, got_d.size(), n); end
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            checks++;
            if (got_d[i] !== mem[i] || got_l[i] !== (i == n - 1) || got_t[i] != t0 + 2 + i) begin
                errors++;
                $display("FAIL %s_word%0d: got %h last=%b t=%0d want %h last=%b t=%0d",
                         nm, i, got_d[i], got_l[i], got_t[i], mem[i], (i == n - 1), t0 + 2 + i);
            end
        end
        checks++; if (done_k != n + 2) begin errors++; $display("FAIL %s_done_time: got k=%0d want %0d", nm, done_k, n + 2); end
        checks++; if (busy_cnt != n + 2) begin errors++; $display("FAIL %s_busy_len: got %0d want %0d", nm, busy_cnt, n + 2); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL %s_addr_bound: got %0d violations want 0", nm, addr_err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b want 0", nm, done); end
    endtask

    task automatic test_stall();
        int first_k, done_k, busy_cnt, t0;
        load_ramp();
        @(negedge clk);
        launch(8, 8);
        run_burst(1, -1, first_k, done_k, busy_cnt, t0);
        checks++; if (done_k < 0 || got_d.size() != 8) begin
            errors++; $display("FAIL stall_count: got %0d words done_k=%0d want 8", got_d.size(), done_k);
        end
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            checks++;
            if (got_d[i] !== mem[i] || got_l[i] !== (i == 7)) begin
                errors++; $display("FAIL stall_word%0d: got %h last=%b want %h last=%b", i, got_d[i], got_l[i], mem[i], (i == 7));
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL stall_addr_ahead: got %0d violations want 0", addr_err); end
    endtask

    task automatic test_back_to_back();
        int first_k, done_k, busy_cnt, t0;
        load_ramp();
        @(negedge clk);
        launch(5, 5);
        run_burst(0, 3, first_k, done_k, busy_cnt, t0);
        checks++; if (got_d.size() != 5 || done_k != 7) begin
            errors++; $display("FAIL b2b_ignore_start: got %0d words done_k=%0d want 5 words done_k=7", got_d.size(), done_k);
        end
        // Still in the done cycle: a start here must be taken.
        launch(4, 4);
        run_burst(0, -1, first_k, done_k, busy_cnt, t0);
        checks++; if (first_k != 2) begin errors++; $display("FAIL b2b_first_valid: got k=%0d want 2", first_k); end
        checks++; if (got_d.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            checks++;
            if (got_d[i] !== mem[i] || got_l[i] !== (i == 3)) begin
                errors++; $display("FAIL b2b_word%0d: got %h last=%b want %h last=%b", i, got_d[i], got_l[i], mem[i], (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_k, done_k, busy_cnt, t0, seen;
        load_ramp();
        @(negedge clk);
        launch(8, 8);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            out_ready = 1'b1;
            if (got_d.size() >= 3) begin
                seen = 1;
                break;
            end
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL rmid_three_words: got %0d words want 3", got_d.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || ram_addr !== 3'd0) begin
            errors++; $display("FAIL rmid_async_clear: busy=%b valid=%b data=%h addr=%0d want 0 0 0 0", busy, out_valid, out_data, ram_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = got_d.size();
        repeat (6) @(negedge clk);
        checks++; if (got_d.size() != seen || out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_no_stale: got %0d words valid=%b want %0d words valid=0", got_d.size(), out_valid, seen);
        end
        launch(4, 4);
        run_burst(0, -1, first_k, done_k, busy_cnt, t0);
        checks++; if (got_d.size() != 4) begin errors++; $display("FAIL rmid_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            checks++;
            if (got_d[i] !== 32'h100 + i || got_l[i] !== (i == 3)) begin
                errors++; $display("FAIL rmid_word%0d: got %h last=%b want %h last=%b", i, got_d[i], got_l[i], 32'h100 + i, (i == 3));
            end
        end
    endtask

    task automatic test_random();
        int first_k, done_k, busy_cnt, t0, n_req, n;
        logic [31:0] exp_d [$];
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 8; i++) mem[i] = $urandom;
            n_req = $urandom_range(0, 15);
            n = clamp_len(n_req);
            exp_d.delete();
            for (int i = 0; i < n; i++) exp_d.push_back(mem[i]);
            @(negedge clk);
            launch(n_req, n);
            run_burst(2, -1, first_k, done_k, busy_cnt, t0);
            checks++; if (done_k < 0 || got_d.size() != n) begin
                errors++; $display("FAIL rand%0d_count: len=%0d got %0d words done_k=%0d want %0d", it, n_req, got_d.size(), done_k, n);
            end
            for (int i = 0; i < got_d.size() && i < n; i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== (i == n - 1)) begin
                    errors++; $display("FAIL rand%0d_word%0d: got %h last=%b want %h last=%b", it, i, got_d[i], got_l[i], exp_d[i], (i == n - 1));
                end
            end
        end
        checks++; if (stall_err != 0 || addr_err != 0) begin
            errors++; $display("FAIL rand_protocol: stall changes=%0d addr violations=%0d want 0 0", stall_err, addr_err);
        end
    endtask

    initial begin
        test_reset();
        test_burst_ready(8, "full");
        test_burst_ready(1, "single");
        test_burst_ready(0, "len0");
        test_burst_ready(9, "len9");
        test_burst_ready(15, "len15");
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bufram_drain
`default_nettype wire

// File: doc/bufram_drain.md
BUFRAM_DRAIN -- requirements
Module: bufram_drain

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: address width of the buffer RAM; buffer depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 clk  input  1  sole clock; all logic is rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to drain a burst; sampled only while busy=0.
REQ-005 len  input  ADDR_WIDTH+1  word count of the burst, legal range 1..2^ADDR_WIDTH; sampled with start.
REQ-006 busy  output  1  high from the cycle after an accepted start until the cycle after the last word handshake.
REQ-007 done  output  1  one-cycle pulse coincident with busy falling.
REQ-008 ram_addr  output  ADDR_WIDTH  read address to the buffer RAM read port.
REQ-009 ram_we  output  4  byte write enables to the buffer RAM read port, constant 4'b0000.
REQ-010 ram_di  output  32  write data to the buffer RAM read port, constant 0.
REQ-011 ram_do  input  32  RAM read data, valid exactly one clk after ram_addr is presented.
REQ-012 out_data  output  32  stream data word.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_ready  input  1  consumer accepts a word when out_valid and out_ready are both high.
REQ-015 out_last  output  1  high with the final word of the burst.

Function
REQ-016 The block SHALL read words from addresses 0..len-1 in ascending order and emit them on the stream in that order, without loss or duplication.
REQ-017 States SHALL be IDLE and RUN. IDLE->RUN on start with busy=0. RUN->IDLE on the handshake of the word with out_last=1.
REQ-018 start while busy=1 SHALL be ignored. len outside 1..2^ADDR_WIDTH SHALL be clamped: 0 -> 1, >2^ADDR_WIDTH -> 2^ADDR_WIDTH.
REQ-019 Output buffering SHALL be a 2-entry FIFO.
REQ-020 A read SHALL be issued only when (FIFO occupancy + reads in flight) < 2.
REQ-021 ram_do SHALL be written into the FIFO in the cycle it is valid.
REQ-022 The issue counter SHALL stop at len. It SHALL NOT wrap past 2^ADDR_WIDTH-1, even when len = 2^ADDR_WIDTH.
REQ-023 With out_ready held high, the first out_valid SHALL occur 2 cycles after start is sampled.
REQ-024 With out_ready held high, the block SHALL then sustain one word per cycle until the last word.
REQ-025 out_data, out_valid and out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 out_last SHALL assert only on the word read from address len-1.
REQ-027 done SHALL pulse in the cycle after the last handshake, which is also the cycle busy drops.
REQ-028 Deassertion of out_ready at any cycle, including the last word, SHALL stall the stream without issuing reads beyond FIFO capacity.
REQ-029 The earliest new start SHALL be accepted in the cycle done is high.
REQ-030 ram_addr SHALL hold its last value when no read is issued.

Reset
REQ-031 On rst_n low, immediately: state IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_addr=0, FIFO empty, in-flight count 0.
REQ-032 Reset mid-burst SHALL abandon the burst; no word SHALL be emitted after rst_n rises until a new start.
REQ-033 Reset deassertion need not be synchronized inside the block; the integrator provides a synchronized rst_n.

Structure
REQ-034 The shared package SHALL hold the state enumeration (IDLE, RUN) and the 32-bit data-width constant.
REQ-035 The 2-entry FIFO SHALL be one sub-module, bufram_drain_fifo, with a valid/ready interface on both sides.
REQ-036 The RAM itself SHALL be outside this block; the block connects to the existing buffer RAM's port B.

Verification
REQ-037 ADDR_WIDTH=3, RAM preloaded 0x100+i, len=8, out_ready=1 -> words 0x100..0x107 on 8 consecutive cycles starting 2 cycles after start; out_last on 0x107; done 1 cycle later.
REQ-038 len=1 -> single word 0x100 with out_last=1; busy high for exactly 3 cycles with out_ready=1.
REQ-039 len=8, out_ready toggling 1,0,0,1,... -> all 8 words in order; data stable during stalls; ram_addr never ahead of handshakes by more than 2.
REQ-040 Second start during busy -> ignored; a start pulsed in the done cycle -> accepted; its first word arrives 2 cycles later.
REQ-041 rst_n low after the 3rd word, then a new start with len=4 -> exactly words 0x100..0x103; no stale words from the first burst.
REQ-042 len=0 -> treated as 1; len=9 -> treated as 8; ram_addr never exceeds 7.
